// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and frame constants used by both
// the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous pin into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/avr_uart_tx.sv
// 8N1 LSB-first serial transmitter toward the AVR, gated by the AVR's
// rx-busy flow-control pin so bytes are never pushed into a full buffer.
module avr_uart_tx #(
  parameter int CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tx,
  input  logic       block,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       busy
);

  import uart_pkg::*;

  localparam int CTR_SIZE = $clog2(CLK_PER_BIT);
  localparam int BIT_W    = $clog2(DATA_BITS);
  localparam logic [CTR_SIZE-1:0] CTR_MAX   = CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0]    LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]    LAST_STOP = BIT_W'(STOP_BITS - 1);

  uart_state_t         state_q, state_n;
  logic [CTR_SIZE-1:0] ctr_q, ctr_n;
  logic [BIT_W-1:0]    bit_q, bit_n;
  logic [7:0]          data_q;
  logic                tx_q, tx_n;
  logic                busy_q;
  logic                block_s;
  logic                accept;
  logic                ctr_wrap;

  sync_2ff u_block_sync (
    .clk (clk),
    .rst (rst),
    .d   (block),
    .q   (block_s)
  );

  assign accept   = (state_q == IDLE) && !busy_q && new_data;
  assign ctr_wrap = (ctr_q == CTR_MAX);

  // tx is registered from the next state so each bit appears the cycle after
  // the edge that enters it, keeping the line glitch-free.
  always_comb begin
    state_n = state_q;
    ctr_n   = ctr_q + CTR_SIZE'(1);
    bit_n   = bit_q;
    tx_n    = 1'b1;

    case (state_q)
      IDLE: begin
        ctr_n = '0;
        bit_n = '0;
        if (accept) state_n = START;
      end
      START: begin
        if (ctr_wrap) begin
          ctr_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (ctr_wrap) begin
          ctr_n = '0;
          if (bit_q == LAST_DATA) begin
            bit_n   = '0;
            state_n = STOP;
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (ctr_wrap) begin
          ctr_n = '0;
          if (bit_q == LAST_STOP) begin
            bit_n   = '0;
            state_n = IDLE;
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        ctr_n   = '0;
        bit_n   = '0;
        state_n = IDLE;
      end
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_q[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ctr_q   <= ctr_n;
      bit_q   <= bit_n;
      if (accept) data_q <= data;
      tx_q    <= tx_n;
      busy_q  <= (state_n != IDLE) | block_s;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_avr_uart_tx.sv
// Self-checking bench for avr_uart_tx: a frame-timing model checked every
// cycle, plus directed frames with hand-computed bit patterns.
module tb_avr_uart_tx;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx;
  logic       block = 1'b0;
  logic [7:0] data = 8'h00;
  logic       new_data = 1'b0;
  logic       busy;

  int checks = 0;
  int failures = 0;

  avr_uart_tx #(.CLK_PER_BIT(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx       (tx),
    .block    (block),
    .data     (data),
    .new_data (new_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Frame-level model: a frame accepted at edge S occupies edges S..S+10N-1,
  // slot 0 is the start bit, slots 1..8 the data LSB first, slot 9 the stop.
  // The block pin reaches busy two edges after it is sampled.
  int         edge_idx = 0;
  int         m_start = 0;
  int         m_pos;
  int         m_slot;
  logic       m_active = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_b1 = 1'b0;
  logic       m_b2 = 1'b0;

  always @(posedge clk) begin
    edge_idx++;
    if (rst) begin
      m_active = 1'b0;
      m_tx     = 1'b1;
      m_busy   = 1'b0;
      m_b1     = 1'b0;
      m_b2     = 1'b0;
      m_ready  = 1'b1;
    end else begin
      if (!m_busy && new_data) begin
        m_active = 1'b1;
        m_start  = edge_idx;
        m_byte   = data;
      end
      m_tx = 1'b1;
      if (m_active) begin
        m_pos = edge_idx - m_start;
        if (m_pos >= 10 * N) begin
          m_active = 1'b0;
        end else begin
          m_slot = m_pos / N;
          if (m_slot == 0)      m_tx = 1'b0;
          else if (m_slot <= 8) m_tx = m_byte[m_slot-1];
        end
      end
      m_busy = m_active | m_b2;
      m_b2   = m_b1;
      m_b1   = block;
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      checks++;
      if (tx !== m_tx) begin
        failures++;
        $display("[TB] FAIL model_tx @%0t: got %b expected %b", $time, tx, m_tx);
      end
      checks++;
      if (busy !== m_busy) begin
        failures++;
        $display("[TB] FAIL model_busy @%0t: got %b expected %b", $time, busy, m_busy);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] timeout");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic nd, input logic [7:0] d, input logic blk);
    new_data = nd;
    data     = d;
    block    = blk;
  endtask

  task automatic check_output(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called in cycle 1 of a frame; samples mid-bit and returns in cycle 10N.
  task automatic capture_frame(output logic [9:0] frame);
    frame = '0;
    for (int c = 1; c <= 10 * N; c++) begin
      if ((c - 1) % N == N / 2) frame[(c-1)/N] = tx;
      if (c != 10 * N) @(negedge clk);
    end
  endtask

  logic [9:0] f0, f1;

  initial begin
    $display("[TB] start, CLK_PER_BIT=%0d", N);
    step(3);
    rst = 1'b0;
    step(50);
    check_output("idle_tx", {9'd0, tx}, 10'd1);
    check_output("idle_busy", {9'd0, busy}, 10'd0);

    // Single byte 0xA5
    apply_stimulus(1'b1, 8'hA5, 1'b0);
    step(1);
    new_data = 1'b0;
    check_output("a5_start_c1", {9'd0, tx}, 10'd0);
    capture_frame(f0);
    check_output("a5_busy_c40", {9'd0, busy}, 10'd1);
    step(1);
    check_output("a5_busy_c41", {9'd0, busy}, 10'd0);
    check_output("a5_frame", f0, 10'b1101001010);

    // Back-to-back with new_data held: 0x00 then 0xFF
    step(2);
    apply_stimulus(1'b1, 8'h00, 1'b0);
    step(1);
    data = 8'hFF;
    capture_frame(f0);
    step(1);
    check_output("b2b_gap_tx_c41", {9'd0, tx}, 10'd1);
    check_output("b2b_gap_busy_c41", {9'd0, busy}, 10'd0);
    step(1);
    check_output("b2b_start_c42", {9'd0, tx}, 10'd0);
    new_data = 1'b0;
    capture_frame(f1);
    check_output("b2b_frame_00", f0, 10'b1000000000);
    check_output("b2b_frame_ff", f1, 10'b1111111110);

    // Flow control: request while blocked is dropped
    step(3);
    block = 1'b1;
    step(2);
    check_output("blk_busy_pre", {9'd0, busy}, 10'd0);
    step(1);
    check_output("blk_busy_rise", {9'd0, busy}, 10'd1);
    apply_stimulus(1'b1, 8'h3C, 1'b1);
    step(1);
    new_data = 1'b0;
    step(20);
    check_output("blk_dropped_tx", {9'd0, tx}, 10'd1);
    block = 1'b0;
    step(2);
    check_output("blk_release_busy_c2", {9'd0, busy}, 10'd1);
    step(1);
    check_output("blk_release_busy_c3", {9'd0, busy}, 10'd0);
    apply_stimulus(1'b1, 8'h3C, 1'b0);
    step(1);
    new_data = 1'b0;
    capture_frame(f0);
    check_output("blk_resend_3c", f0, 10'b1001111000);

    // block rises mid-frame carrying 0x81
    step(3);
    apply_stimulus(1'b1, 8'h81, 1'b0);
    step(1);
    new_data = 1'b0;
    f0 = '0;
    for (int c = 1; c <= 53; c++) begin
      if (c == 15) block = 1'b1;
      if (c == 50) block = 1'b0;
      if (c <= 10 * N && (c - 1) % N == N / 2) f0[(c-1)/N] = tx;
      if (c == 45) check_output("mid_blk_busy_c45", {9'd0, busy}, 10'd1);
      if (c == 52) check_output("mid_blk_busy_c52", {9'd0, busy}, 10'd1);
      if (c == 53) check_output("mid_blk_busy_c53", {9'd0, busy}, 10'd0);
      if (c != 53) @(negedge clk);
    end
    check_output("mid_blk_frame_81", f0, 10'b1100000010);

    // Reset mid-frame truncates it; next byte is clean
    step(3);
    apply_stimulus(1'b1, 8'h5A, 1'b0);
    step(1);
    new_data = 1'b0;
    step(19);
    rst = 1'b1;
    step(1);
    check_output("rst_tx", {9'd0, tx}, 10'd1);
    check_output("rst_busy", {9'd0, busy}, 10'd0);
    rst = 1'b0;
    step(5);
    apply_stimulus(1'b1, 8'h55, 1'b0);
    step(1);
    new_data = 1'b0;
    capture_frame(f0);
    check_output("post_rst_frame_55", f0, 10'b1010101010);

    // block rising with the accept: byte still goes out
    step(2);
    apply_stimulus(1'b1, 8'hC3, 1'b1);
    step(1);
    new_data = 1'b0;
    capture_frame(f0);
    check_output("same_cycle_blk_frame_c3", f0, 10'b1110000110);
    step(1);
    check_output("same_cycle_blk_busy_c41", {9'd0, busy}, 10'd1);
    block = 1'b0;
    step(3);
    check_output("same_cycle_blk_busy_c44", {9'd0, busy}, 10'd0);

    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
